ddr_test_sequencer: RTL and testbench
=====================================

Name: ddr_test_sequencer

Overview:
- Top-level sequencer for the DDR self-test.
- Issues AXI write bursts over a configurable address window, then reads the window back.
- Drives the write-data generator controls (WrAddrIn/WrStartEn/WriteEn) and the read-checker controls (RdAddrIn/RdDataEn).
- Counts checker errors and completed passes; sits between the test datapath and the DDR controller AXI port.

Parameters:
- AXI_DATA_WIDTH, 256, data bus width; beat stride AXI_BYTE_NUM = AXI_DATA_WIDTH/8 bytes.
- BURST_LEN, 16, beats per burst (1..256); AwLen/ArLen = BURST_LEN-1.
- BURST_NUM, 64, bursts per pass (>=1).
- ADDR_BASE, 32'h0, first burst byte address; must be aligned to BURST_LEN*AXI_BYTE_NUM.

Ports:
- SysClk  in  1  system clock
- SysRst_N  in  1  asynchronous active-low reset
- TestStart  in  1  level; test runs while high
- TestLoop  in  1  1 = repeat passes; 0 = stop after one pass
- AwAddr  out  32  write burst address
- AwLen  out  8  BURST_LEN-1
- AwValid  out  1  write address valid
- AwReady  in  1  write address ready
- WValid  out  1  write data valid
- WLast  out  1  last write beat
- WReady  in  1  write data ready
- BValid  in  1  write response valid
- BReady  out  1  write response ready
- ArAddr  out  32  read burst address
- ArLen  out  8  BURST_LEN-1
- ArValid  out  1  read address valid
- ArReady  in  1  read address ready
- RValid  in  1  read data valid
- RLast  in  1  last read beat
- RReady  out  1  read data ready (constant 1 outside IDLE)
- WrAddrIn  out  32  generator burst address
- WrStartEn  out  1  generator preload pulse
- WriteEn  out  1  generator advance (WValid & WReady)
- RdAddrIn  out  32  checker beat address
- RdDataEn  out  1  checker data strobe (RValid & RReady)
- DdrRdError  in  1  checker error pulse
- ErrCnt  out  16  saturating error count
- PassCnt  out  16  wrapping count of completed passes
- TestBusy  out  1  state != IDLE
- TestDone  out  1  single-pass run finished

Behaviour:
- Reset: state IDLE; all valids, WrStartEn and TestDone are 0; all addresses equal ADDR_BASE; ErrCnt = PassCnt = 0; burst and beat counters are 0.
- Address of burst k = ADDR_BASE + k*BURST_LEN*AXI_BYTE_NUM (32-bit, wraps modulo 2^32). Beat b adds b*AXI_BYTE_NUM.
- States:
  - IDLE: on TestStart rising edge, clear ErrCnt and TestDone; go to WR_ADDR with burst counter = 0.
  - WR_ADDR: AwValid=1 and AwAddr held until AwReady; on handshake go to WR_PREP.
  - WR_PREP: exactly 1 cycle; WrStartEn=1, WrAddrIn=AwAddr. The generator therefore holds beat 0 data before the first WValid cycle.
  - WR_DATA: WValid=1; beat advances only on WValid&WReady. WLast=1 on beat BURST_LEN-1. After the last handshake go to WR_RESP.
  - WR_RESP: BReady=1; on BValid, increment the burst counter. If it was BURST_NUM-1, go to RD_ADDR with the counter reset to 0; else go to WR_ADDR.
  - RD_ADDR: ArValid=1 until ArReady; on handshake set RdAddrIn=ArAddr and go to RD_DATA.
  - RD_DATA: RReady=1; RdDataEn = RValid. RdAddrIn advances by AXI_BYTE_NUM after each accepted beat. On accepted RLast: if last burst, go to DRAIN; else go to RD_ADDR.
  - DRAIN: 4 cycles so checker errors (2-cycle latency) are still counted; then PassCnt+1. Continue to WR_ADDR if TestLoop&TestStart; else go to IDLE and set TestDone=1 if TestStart is still high.
- Valid signals never drop before their handshake completes.
- WR_ADDR is never entered mid-burst.
- ErrCnt increments on every cycle with DdrRdError in any state, and saturates at 16'hFFFF.
- TestStart low mid-test: finish the current burst (write or read, including its response) so the AXI port is left clean, then go to IDLE. Counters are retained; TestDone stays 0.
- RLast on a beat other than BURST_LEN-1 (mismatch): count 1 error, and move on as if the burst ended.
- Asynchronous reset mid-burst: immediate return to reset values; the DDR controller is reset alongside.

Test Plan:
- BURST_LEN=4, BURST_NUM=2, always-ready slave, TestLoop=0: AwAddr 0x0 then 0x80; WrStartEn 1 cycle before each first WValid; 8 WriteEn; ArAddr 0x0, 0x80; RdAddrIn steps 0x0,0x20,...,0xE0; PassCnt=1, TestDone=1, ErrCnt=0.
- WReady toggled every other cycle: WValid and WLast held through stalls; exactly 4 WriteEn pulses per burst; WLast coincides with the 4th handshake.
- Inject DdrRdError for 3 cycles, including one in DRAIN: ErrCnt=3. Force 70000 pulses: ErrCnt sticks at 0xFFFF.
- TestStart dropped during the 2nd write beat: burst completes through BValid, then IDLE; TestBusy=0, TestDone=0.
- TestLoop=1 for 3 passes: PassCnt=3; addresses restart at ADDR_BASE each pass.
- SysRst_N asserted during RD_DATA: all outputs return to reset values asynchronously; restart runs cleanly.

Source files
------------

// File: rtl/ddr_test_sequencer.sv
// DDR self-test sequencer: writes BURST_NUM AXI bursts over an address window, reads
// them back through the checker, then counts checker errors and completed passes.
module ddr_test_sequencer #(
   parameter int          AXI_DATA_WIDTH = 256,
   parameter int          BURST_LEN      = 16,
   parameter int          BURST_NUM      = 64,
   parameter logic [31:0] ADDR_BASE      = 32'h0
) (
   input  logic        SysClk,
   input  logic        SysRst_N,
   input  logic        TestStart,
   input  logic        TestLoop,
   output logic [31:0] AwAddr,
   output logic [7:0]  AwLen,
   output logic        AwValid,
   input  logic        AwReady,
   output logic        WValid,
   output logic        WLast,
   input  logic        WReady,
   input  logic        BValid,
   output logic        BReady,
   output logic [31:0] ArAddr,
   output logic [7:0]  ArLen,
   output logic        ArValid,
   input  logic        ArReady,
   input  logic        RValid,
   input  logic        RLast,
   output logic        RReady,
   output logic [31:0] WrAddrIn,
   output logic        WrStartEn,
   output logic        WriteEn,
   output logic [31:0] RdAddrIn,
   output logic        RdDataEn,
   input  logic        DdrRdError,
   output logic [15:0] ErrCnt,
   output logic [15:0] PassCnt,
   output logic        TestBusy,
   output logic        TestDone
);

   localparam int          AXI_BYTE_NUM = AXI_DATA_WIDTH / 8;
   localparam logic [31:0] BEAT_BYTES   = 32'(AXI_BYTE_NUM);
   localparam logic [31:0] BURST_BYTES  = 32'(BURST_LEN * AXI_BYTE_NUM);
   localparam logic [8:0]  LAST_BEAT    = 9'(BURST_LEN - 1);
   localparam logic [31:0] LAST_BURST   = 32'(BURST_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_PREP, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] burst_q, burst_d;
   logic [8:0]  beat_q, beat_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [15:0] pass_cnt_q, pass_cnt_d;
   logic        done_q, done_d;
   logic [1:0]  drain_q, drain_d;
   logic        start_q;

   logic        rd_beat;
   logic        rlast_bad;
   logic [1:0]  err_add;
   logic [16:0] err_sum;

   assign AwAddr    = addr_q;
   assign ArAddr    = addr_q;
   assign WrAddrIn  = addr_q;
   assign AwLen     = 8'(BURST_LEN - 1);
   assign ArLen     = 8'(BURST_LEN - 1);
   assign AwValid   = (state_q == S_WR_ADDR);
   assign WrStartEn = (state_q == S_WR_PREP);
   assign WValid    = (state_q == S_WR_DATA);
   assign WLast     = (state_q == S_WR_DATA) && (beat_q == LAST_BEAT);
   assign WriteEn   = WValid & WReady;
   assign BReady    = (state_q == S_WR_RESP);
   assign ArValid   = (state_q == S_RD_ADDR);
   assign RReady    = (state_q != S_IDLE);
   assign RdDataEn  = RValid & (state_q == S_RD_DATA);
   assign RdAddrIn  = rd_addr_q;
   assign ErrCnt    = err_cnt_q;
   assign PassCnt   = pass_cnt_q;
   assign TestBusy  = (state_q != S_IDLE);
   assign TestDone  = done_q;

   // A premature RLast is charged as one checker error on top of any DdrRdError pulse.
   assign rd_beat   = RdDataEn;
   assign rlast_bad = rd_beat & RLast & (beat_q != LAST_BEAT);
   assign err_add   = {1'b0, DdrRdError} + {1'b0, rlast_bad};
   assign err_sum   = {1'b0, err_cnt_q} + {15'd0, err_add};

   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      beat_d     = beat_q;
      addr_d     = addr_q;
      rd_addr_d  = rd_addr_q;
      pass_cnt_d = pass_cnt_q;
      done_d     = done_q;
      drain_d    = drain_q;
      err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

      case (state_q)
         S_IDLE: begin
            if (TestStart && !start_q) begin
               err_cnt_d = 16'd0;
               done_d    = 1'b0;
               burst_d   = 32'd0;
               beat_d    = 9'd0;
               addr_d    = ADDR_BASE;
               state_d   = S_WR_ADDR;
            end
         end
         S_WR_ADDR: if (AwReady) state_d = S_WR_PREP;
         S_WR_PREP: state_d = S_WR_DATA;
         S_WR_DATA: begin
            if (WReady) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = 9'd0;
                  state_d = S_WR_RESP;
               end else begin
                  beat_d = beat_q + 9'd1;
               end
            end
         end
         S_WR_RESP: begin
            if (BValid) begin
               if (!TestStart) begin
                  state_d = S_IDLE;
               end else if (burst_q == LAST_BURST) begin
                  burst_d = 32'd0;
                  addr_d  = ADDR_BASE;
                  state_d = S_RD_ADDR;
               end else begin
                  burst_d = burst_q + 32'd1;
                  addr_d  = addr_q + BURST_BYTES;
                  state_d = S_WR_ADDR;
               end
            end
         end
         S_RD_ADDR: begin
            if (ArReady) begin
               rd_addr_d = addr_q;
               beat_d    = 9'd0;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rd_beat) begin
               rd_addr_d = rd_addr_q + BEAT_BYTES;
               beat_d    = beat_q + 9'd1;
               if (RLast) begin
                  beat_d = 9'd0;
                  if (burst_q == LAST_BURST) begin
                     drain_d = 2'd0;
                     state_d = S_DRAIN;
                  end else if (!TestStart) begin
                     state_d = S_IDLE;
                  end else begin
                     burst_d = burst_q + 32'd1;
                     addr_d  = addr_q + BURST_BYTES;
                     state_d = S_RD_ADDR;
                  end
               end
            end
         end
         S_DRAIN: begin
            // Hold off the pass decision until late checker errors have landed.
            drain_d = drain_q + 2'd1;
            if (drain_q == 2'd3) begin
               pass_cnt_d = pass_cnt_q + 16'd1;
               burst_d    = 32'd0;
               addr_d     = ADDR_BASE;
               if (TestLoop && TestStart) begin
                  state_d = S_WR_ADDR;
               end else begin
                  done_d  = TestStart;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge SysClk or negedge SysRst_N) begin
      if (!SysRst_N) begin
         state_q    <= S_IDLE;
         burst_q    <= 32'd0;
         beat_q     <= 9'd0;
         addr_q     <= ADDR_BASE;
         rd_addr_q  <= ADDR_BASE;
         err_cnt_q  <= 16'd0;
         pass_cnt_q <= 16'd0;
         done_q     <= 1'b0;
         drain_q    <= 2'd0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         beat_q     <= beat_d;
         addr_q     <= addr_d;
         rd_addr_q  <= rd_addr_d;
         err_cnt_q  <= err_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         done_q     <= done_d;
         drain_q    <= drain_d;
         start_q    <= TestStart;
      end
   end

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Directed bench for ddr_test_sequencer: small AXI slave, handshake monitor and
// one task per scenario with hand-computed expectations (BURST_LEN=4, BURST_NUM=2).
module tb_ddr_test_sequencer;

   localparam int BL = 4;

   logic        SysClk = 1'b0;
   logic        SysRst_N, TestStart, TestLoop;
   logic [31:0] AwAddr, ArAddr, WrAddrIn, RdAddrIn;
   logic [7:0]  AwLen, ArLen;
   logic        AwValid, AwReady, WValid, WLast, WReady, BValid, BReady;
   logic        ArValid, ArReady, RValid, RLast, RReady;
   logic        WrStartEn, WriteEn, RdDataEn, DdrRdError, TestBusy, TestDone;
   logic [15:0] ErrCnt, PassCnt;

   int n_cmp = 0;
   int n_err = 0;

   // slave configuration (written by the main process only)
   int wready_mode = 0;
   bit rlast_early = 1'b0;

   // slave state (written by the slave process only)
   bit b_pend, hs_wl, hs_b, hs_ar, hs_r, hs_rl, wtog;
   int r_left, r_beat;

   // monitor state (written by the monitor process only)
   int n_wren = 0, n_prep_ok = 0, n_wlast_ok = 0, n_wdrop = 0, n_bhs = 0, n_ws = 0;
   int wbeat = 0;
   bit prev_ws, prev_wv, prev_whs;
   logic [31:0] aw_q[$], ar_q[$], rd_q[$];

   ddr_test_sequencer #(.AXI_DATA_WIDTH(256), .BURST_LEN(BL), .BURST_NUM(2), .ADDR_BASE(32'h0)) dut (
      .SysClk(SysClk), .SysRst_N(SysRst_N), .TestStart(TestStart), .TestLoop(TestLoop),
      .AwAddr(AwAddr), .AwLen(AwLen), .AwValid(AwValid), .AwReady(AwReady),
      .WValid(WValid), .WLast(WLast), .WReady(WReady), .BValid(BValid), .BReady(BReady),
      .ArAddr(ArAddr), .ArLen(ArLen), .ArValid(ArValid), .ArReady(ArReady),
      .RValid(RValid), .RLast(RLast), .RReady(RReady),
      .WrAddrIn(WrAddrIn), .WrStartEn(WrStartEn), .WriteEn(WriteEn),
      .RdAddrIn(RdAddrIn), .RdDataEn(RdDataEn), .DdrRdError(DdrRdError),
      .ErrCnt(ErrCnt), .PassCnt(PassCnt), .TestBusy(TestBusy), .TestDone(TestDone)
   );

   initial forever #5 SysClk = ~SysClk;

   // AXI slave: drives at the falling edge, predicts the next rising-edge handshakes at +1
   initial begin
      AwReady = 0; WReady = 0; BValid = 0; ArReady = 0; RValid = 0; RLast = 0;
      b_pend = 0; hs_wl = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_rl = 0; wtog = 0;
      r_left = 0; r_beat = 0;
      forever begin
         @(negedge SysClk);
         if (!SysRst_N) begin
            b_pend = 0; hs_wl = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_rl = 0;
            r_left = 0; r_beat = 0;
            AwReady = 0; WReady = 0; BValid = 0; ArReady = 0; RValid = 0; RLast = 0;
         end else begin
            if (hs_wl) b_pend = 1;
            if (hs_b) b_pend = 0;
            if (hs_ar) begin r_left = BL; r_beat = 0; end
            if (hs_r) begin
               if (hs_rl) r_left = 0;
               else begin r_left--; r_beat++; end
            end
            wtog    = !wtog;
            AwReady = 1;
            ArReady = 1;
            WReady  = (wready_mode == 0) ? 1'b1 : wtog;
            BValid  = b_pend;
            RValid  = (r_left > 0);
            RLast   = RValid && (rlast_early ? (r_beat == 1) : (r_beat == BL - 1));
            #1;
            hs_wl = WValid && WReady && WLast;
            hs_b  = BValid && BReady;
            hs_ar = ArValid && ArReady;
            hs_r  = RValid && RReady;
            hs_rl = hs_r && RLast;
         end
      end
   end

   // monitor: logs what will be accepted at the coming rising edge
   initial begin
      prev_ws = 0; prev_wv = 0; prev_whs = 0;
      forever begin
         @(negedge SysClk);
         #2;
         if (!SysRst_N) begin
            prev_ws = 0; prev_wv = 0; prev_whs = 0; wbeat = 0;
         end else begin
            if (WValid && !prev_wv && prev_ws) n_prep_ok++;
            if (prev_wv && !prev_whs && !WValid) n_wdrop++;
            if (WrStartEn) n_ws++;
            if (WriteEn) begin
               n_wren++;
               if (WLast) begin
                  if (wbeat == BL - 1) n_wlast_ok++;
                  wbeat = 0;
               end else begin
                  wbeat++;
               end
            end
            if (BValid && BReady) n_bhs++;
            if (AwValid && AwReady) begin aw_q.push_back(AwAddr); $display("AW  addr=%h", AwAddr); end
            if (ArValid && ArReady) begin ar_q.push_back(ArAddr); $display("AR  addr=%h", ArAddr); end
            if (RdDataEn) rd_q.push_back(RdAddrIn);
            prev_ws = WrStartEn; prev_wv = WValid; prev_whs = WriteEn;
         end
      end
   end

   task automatic start_test();
      @(negedge SysClk); #3;
      TestStart = 0;
      repeat (2) @(negedge SysClk);
      #3;
      TestStart = 1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge SysClk); #3;
         if (!TestBusy) begin seen = 1; break; end
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL %s_idle_timeout: got busy after %0d cycles want idle", name, budget); end
   endtask

   task automatic test_reset();
      SysRst_N = 0; TestStart = 0; TestLoop = 0; DdrRdError = 0;
      repeat (3) @(negedge SysClk);
      #3;
      n_cmp++; if (TestBusy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", TestBusy); end
      n_cmp++; if ({AwValid, WValid, ArValid, WrStartEn, BReady} !== 5'b0) begin n_err++; $display("FAIL rst_valids: got %b want 00000", {AwValid, WValid, ArValid, WrStartEn, BReady}); end
      n_cmp++; if (TestDone !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", TestDone); end
      n_cmp++; if (ErrCnt !== 16'd0 || PassCnt !== 16'd0) begin n_err++; $display("FAIL rst_counts: got err=%h pass=%h want 0/0", ErrCnt, PassCnt); end
      n_cmp++; if (AwAddr !== 32'h0 || ArAddr !== 32'h0 || RdAddrIn !== 32'h0 || WrAddrIn !== 32'h0) begin n_err++; $display("FAIL rst_addrs: got %h %h %h %h want 0", AwAddr, ArAddr, RdAddrIn, WrAddrIn); end
      n_cmp++; if (AwLen !== 8'd3 || ArLen !== 8'd3) begin n_err++; $display("FAIL rst_len: got %h/%h want 03/03", AwLen, ArLen); end
      n_cmp++; if (RReady !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", RReady); end
      SysRst_N = 1;
      repeat (2) @(negedge SysClk);
      #3;
      n_cmp++; if (TestBusy !== 1'b0) begin n_err++; $display("FAIL rst_release_busy: got %b want 0", TestBusy); end
      $display("test_reset done");
   endtask

   task automatic test_single_pass();
      int b_aw = aw_q.size(), b_ar = ar_q.size(), b_rd = rd_q.size();
      int b_wren = n_wren, b_prep = n_prep_ok, b_ws = n_ws;
      TestLoop = 0;
      start_test();
      wait_idle("single", 500);
      n_cmp++; if (aw_q.size() - b_aw != 2) begin n_err++; $display("FAIL single_aw_count: got %0d want 2", aw_q.size() - b_aw); end
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (aw_q[b_aw + i] !== 32'(i * 32'h80)) begin n_err++; $display("FAIL single_awaddr%0d: got %h want %h", i, aw_q[b_aw + i], i * 32'h80); end
         n_cmp++; if (ar_q[b_ar + i] !== 32'(i * 32'h80)) begin n_err++; $display("FAIL single_araddr%0d: got %h want %h", i, ar_q[b_ar + i], i * 32'h80); end
      end
      n_cmp++; if (n_wren - b_wren != 8) begin n_err++; $display("FAIL single_wren: got %0d want 8", n_wren - b_wren); end
      n_cmp++; if (n_prep_ok - b_prep != 2 || n_ws - b_ws != 2) begin n_err++; $display("FAIL single_wrstart: got prep_ok=%0d starts=%0d want 2/2", n_prep_ok - b_prep, n_ws - b_ws); end
      n_cmp++; if (rd_q.size() - b_rd != 8) begin n_err++; $display("FAIL single_rd_count: got %0d want 8", rd_q.size() - b_rd); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (rd_q[b_rd + i] !== 32'(i * 32'h20)) begin n_err++; $display("FAIL single_rdaddr%0d: got %h want %h", i, rd_q[b_rd + i], i * 32'h20); end
      end
      n_cmp++; if (PassCnt !== 16'd1) begin n_err++; $display("FAIL single_pass: got %0d want 1", PassCnt); end
      n_cmp++; if (TestDone !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", TestDone); end
      n_cmp++; if (ErrCnt !== 16'd0) begin n_err++; $display("FAIL single_err: got %0d want 0", ErrCnt); end
      $display("test_single_pass done");
   endtask

   task automatic test_back_to_back_wready_stall();
      int b_wren = n_wren, b_wl = n_wlast_ok, b_drop = n_wdrop;
      wready_mode = 1;
      start_test();
      wait_idle("stall", 500);
      n_cmp++; if (n_wren - b_wren != 8) begin n_err++; $display("FAIL stall_wren: got %0d want 8", n_wren - b_wren); end
      n_cmp++; if (n_wlast_ok - b_wl != 2) begin n_err++; $display("FAIL stall_wlast_on_4th: got %0d want 2", n_wlast_ok - b_wl); end
      n_cmp++; if (n_wdrop - b_drop != 0) begin n_err++; $display("FAIL stall_wvalid_drop: got %0d want 0", n_wdrop - b_drop); end
      n_cmp++; if (PassCnt !== 16'd2) begin n_err++; $display("FAIL stall_pass: got %0d want 2", PassCnt); end
      n_cmp++; if (TestDone !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", TestDone); end
      wready_mode = 0;
      $display("test_back_to_back_wready_stall done");
   endtask

   task automatic test_errors();
      bit found = 0;
      start_test();
      repeat (3) @(negedge SysClk);
      #3; DdrRdError = 1;
      repeat (2) @(negedge SysClk);
      #3; DdrRdError = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge SysClk); #3;
         if (RdDataEn && RLast && RdAddrIn == 32'hE0) begin found = 1; break; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL err_last_beat_timeout: got none want beat at 0xE0"); end
      @(negedge SysClk); #3; DdrRdError = 1;
      @(negedge SysClk); #3; DdrRdError = 0;
      wait_idle("errors", 100);
      n_cmp++; if (ErrCnt !== 16'd3) begin n_err++; $display("FAIL err_count: got %0d want 3", ErrCnt); end
      n_cmp++; if (PassCnt !== 16'd3) begin n_err++; $display("FAIL err_pass: got %0d want 3", PassCnt); end
      $display("test_errors done");
   endtask

   task automatic test_rlast_mismatch();
      int b_rd = rd_q.size();
      rlast_early = 1;
      start_test();
      wait_idle("rlast", 500);
      n_cmp++; if (ErrCnt !== 16'd2) begin n_err++; $display("FAIL rlast_err: got %0d want 2", ErrCnt); end
      n_cmp++; if (rd_q.size() - b_rd != 4) begin n_err++; $display("FAIL rlast_beats: got %0d want 4", rd_q.size() - b_rd); end
      n_cmp++; if (rd_q[b_rd + 2] !== 32'h80) begin n_err++; $display("FAIL rlast_burst1_addr: got %h want 00000080", rd_q[b_rd + 2]); end
      n_cmp++; if (PassCnt !== 16'd4 || TestDone !== 1'b1) begin n_err++; $display("FAIL rlast_pass: got pass=%0d done=%b want 4/1", PassCnt, TestDone); end
      rlast_early = 0;
      $display("test_rlast_mismatch done");
   endtask

   task automatic test_err_saturation();
      @(negedge SysClk); #3; DdrRdError = 1;
      repeat (65532) @(negedge SysClk);
      #3;
      n_cmp++; if (ErrCnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want FFFE", ErrCnt); end
      @(negedge SysClk); #3;
      n_cmp++; if (ErrCnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h want FFFF", ErrCnt); end
      repeat (100) @(negedge SysClk);
      #3;
      n_cmp++; if (ErrCnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want FFFF", ErrCnt); end
      DdrRdError = 0;
      $display("test_err_saturation done");
   endtask

   task automatic test_stop_midburst();
      int b_aw = aw_q.size(), b_ar = ar_q.size(), b_wren = n_wren, b_b = n_bhs;
      bit found = 0;
      start_test();
      for (int i = 0; i < 100; i++) begin
         @(negedge SysClk); #3;
         if (n_wren - b_wren == 2) begin found = 1; break; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL stop_beat2_timeout: got %0d beats want 2", n_wren - b_wren); end
      TestStart = 0;
      wait_idle("stop", 100);
      n_cmp++; if (n_wren - b_wren != 4) begin n_err++; $display("FAIL stop_wren: got %0d want 4", n_wren - b_wren); end
      n_cmp++; if (n_bhs - b_b != 1) begin n_err++; $display("FAIL stop_bresp: got %0d want 1", n_bhs - b_b); end
      n_cmp++; if (aw_q.size() - b_aw != 1 || ar_q.size() - b_ar != 0) begin n_err++; $display("FAIL stop_addr_count: got aw=%0d ar=%0d want 1/0", aw_q.size() - b_aw, ar_q.size() - b_ar); end
      n_cmp++; if (TestDone !== 1'b0) begin n_err++; $display("FAIL stop_done: got %b want 0", TestDone); end
      n_cmp++; if (PassCnt !== 16'd4 || ErrCnt !== 16'd0) begin n_err++; $display("FAIL stop_counts: got pass=%0d err=%0d want 4/0", PassCnt, ErrCnt); end
      $display("test_stop_midburst done");
   endtask

   task automatic test_loop();
      int b_aw = aw_q.size(), b_ar = ar_q.size();
      bit found = 0;
      TestLoop = 1;
      start_test();
      for (int i = 0; i < 1000; i++) begin
         @(negedge SysClk); #3;
         if (PassCnt == 16'd7) begin found = 1; break; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL loop_pass_timeout: got %0d want 7", PassCnt); end
      TestStart = 0;
      wait_idle("loop", 100);
      n_cmp++; if (PassCnt !== 16'd7) begin n_err++; $display("FAIL loop_pass: got %0d want 7", PassCnt); end
      n_cmp++; if (aw_q.size() - b_aw != 7 || ar_q.size() - b_ar != 6) begin n_err++; $display("FAIL loop_addr_count: got aw=%0d ar=%0d want 7/6", aw_q.size() - b_aw, ar_q.size() - b_ar); end
      for (int i = 0; i < 7; i++) begin
         n_cmp++; if (aw_q[b_aw + i] !== 32'((i % 2) * 32'h80)) begin n_err++; $display("FAIL loop_awaddr%0d: got %h want %h", i, aw_q[b_aw + i], (i % 2) * 32'h80); end
      end
      n_cmp++; if (ar_q[b_ar + 4] !== 32'h0 || ar_q[b_ar + 5] !== 32'h80) begin n_err++; $display("FAIL loop_araddr_pass3: got %h %h want 0 80", ar_q[b_ar + 4], ar_q[b_ar + 5]); end
      n_cmp++; if (TestDone !== 1'b0) begin n_err++; $display("FAIL loop_done: got %b want 0", TestDone); end
      TestLoop = 0;
      $display("test_loop done");
   endtask

   task automatic test_async_reset();
      int b_rd, b_wren;
      bit found = 0;
      start_test();
      for (int i = 0; i < 300; i++) begin
         @(negedge SysClk); #3;
         if (RdDataEn) begin found = 1; break; end
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL arst_rd_timeout: got no read beat want one"); end
      #1; SysRst_N = 0;
      #1;
      n_cmp++; if (TestBusy !== 1'b0 || ArValid !== 1'b0 || RReady !== 1'b0 || RdDataEn !== 1'b0) begin n_err++; $display("FAIL arst_ctrl: got busy=%b arv=%b rr=%b rde=%b want 0", TestBusy, ArValid, RReady, RdDataEn); end
      n_cmp++; if (RdAddrIn !== 32'h0 || ArAddr !== 32'h0) begin n_err++; $display("FAIL arst_addr: got %h %h want 0", RdAddrIn, ArAddr); end
      n_cmp++; if (PassCnt !== 16'd0 || ErrCnt !== 16'd0 || TestDone !== 1'b0) begin n_err++; $display("FAIL arst_counts: got pass=%0d err=%0d done=%b want 0", PassCnt, ErrCnt, TestDone); end
      TestStart = 0;
      repeat (3) @(negedge SysClk);
      #3; SysRst_N = 1;
      b_rd = rd_q.size(); b_wren = n_wren;
      start_test();
      wait_idle("arst_restart", 500);
      n_cmp++; if (PassCnt !== 16'd1 || TestDone !== 1'b1) begin n_err++; $display("FAIL arst_restart_pass: got pass=%0d done=%b want 1/1", PassCnt, TestDone); end
      n_cmp++; if (n_wren - b_wren != 8 || rd_q.size() - b_rd != 8) begin n_err++; $display("FAIL arst_restart_beats: got w=%0d r=%0d want 8/8", n_wren - b_wren, rd_q.size() - b_rd); end
      n_cmp++; if (ErrCnt !== 16'd0) begin n_err++; $display("FAIL arst_restart_err: got %0d want 0", ErrCnt); end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_back_to_back_wready_stall();
      test_errors();
      test_rlast_mismatch();
      test_err_saturation();
      test_stop_midburst();
      test_loop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
